// File: rtl/spart_arb_pkg.sv
// Shared types and constants for the SPART bus arbiter.
package spart_arb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LATCH    = 3'd1,
        S_WAIT_TBR = 3'd2,
        S_ISSUE    = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_BUF    = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_DIV_HI = 2'b11;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    // Only transmit-buffer writes must wait for tbr.
    function automatic logic needs_tbr(input logic rw, input logic [ADDR_W-1:0] addr);
        return (rw == WR) && (addr == ADDR_BUF);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; a lock bit grants that side exclusively.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic [1:0] lock,
    output logic       sel,
    output logic       valid
);

    always_comb begin
        sel   = 1'b0;
        valid = 1'b0;
        if (lock[0]) begin
            sel   = 1'b0;
            valid = req[0];
        end else if (lock[1]) begin
            sel   = 1'b1;
            valid = req[1];
        end else if (req == 2'b11) begin
            sel   = ~ptr;
            valid = 1'b1;
        end else if (req[1]) begin
            sel   = 1'b1;
            valid = 1'b1;
        end else if (req[0]) begin
            sel   = 1'b0;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/spart_bus_arbiter.sv
// Serialises two requesters onto the SPART I/O bus with round-robin priority and tbr gating.
// Optional owner lock for atomic register pairs: define SPART_ARB_LOCK_EN.
module spart_bus_arbiter
    import spart_arb_pkg::*;
#(
    parameter int unsigned       CNT_W       = 16,
    parameter logic [CNT_W-1:0]  TBR_TIMEOUT = 16'd65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
`ifdef SPART_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              iocs,
    output logic              iorw,
    output logic [ADDR_W-1:0] ioaddr,
    inout  wire  [DATA_W-1:0] databus,
    input  logic              tbr
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              lock_hold_q, lock_hold_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              err_q, err_d;
    logic              iocs_q, iocs_d, iorw_q, iorw_d;
    logic [ADDR_W-1:0] ioaddr_q, ioaddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              drive_q, drive_d;

    logic [1:0] lock_in;
    logic [1:0] lock_vec;
    logic       arb_sel, arb_valid;
    logic       owner_lock;

`ifdef SPART_ARB_LOCK_EN
    assign lock_in = {lock1, lock0};
`else
    assign lock_in = 2'b00;
`endif

    // Only the owner that kept its lock through DONE holds exclusive priority.
    assign lock_vec[0] = lock_hold_q && !owner_q && lock_in[0];
    assign lock_vec[1] = lock_hold_q &&  owner_q && lock_in[1];
    assign owner_lock  = owner_q ? lock_in[1] : lock_in[0];

    rr_arb2 u_rr_arb2 (
        .req   ({req1, req0}),
        .ptr   (rr_ptr_q),
        .lock  (lock_vec),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        lock_hold_d = lock_hold_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;
        iocs_d      = 1'b0;
        iorw_d      = RD;
        ioaddr_d    = ADDR_BUF;
        drive_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_sel;
                    rw_d    = arb_sel ? rw1    : rw0;
                    addr_d  = arb_sel ? addr1  : addr0;
                    wdata_d = arb_sel ? wdata1 : wdata0;
                    gnt0_d  = !arb_sel;
                    gnt1_d  = arb_sel;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (needs_tbr(rw_q, addr_q) && !tbr) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_TBR;
                end else begin
                    iocs_d   = 1'b1;
                    iorw_d   = rw_q;
                    ioaddr_d = addr_q;
                    drive_d  = (rw_q == WR);
                    state_d  = S_ISSUE;
                end
            end
            S_WAIT_TBR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (tbr) begin
                    iocs_d   = 1'b1;
                    iorw_d   = rw_q;
                    ioaddr_d = addr_q;
                    drive_d  = 1'b1;
                    state_d  = S_ISSUE;
                end else if (cnt_q == CNT_W'(TBR_TIMEOUT - CNT_W'(1))) begin
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_ISSUE: begin
                if (rw_q == RD) begin
                    rdata_d = databus;
                end
                done0_d = !owner_q;
                done1_d = owner_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                lock_hold_d = owner_lock;
                if (!owner_lock) begin
                    rr_ptr_d = owner_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b1;
            lock_hold_q <= 1'b0;
            rw_q        <= RD;
            addr_q      <= ADDR_BUF;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= 8'hFF;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            iocs_q      <= 1'b0;
            iorw_q      <= RD;
            ioaddr_q    <= ADDR_BUF;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_hold_q <= lock_hold_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err_q       <= err_d;
            iocs_q      <= iocs_d;
            iorw_q      <= iorw_d;
            ioaddr_q    <= ioaddr_d;
            drive_q     <= drive_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err     = err_q;
    assign iocs    = iocs_q;
    assign iorw    = iorw_q;
    assign ioaddr  = ioaddr_q;
    assign rdata   = rdata_q;
    assign databus = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench: instance a uses the default tbr timeout, instance b a short one (8).
module tb_spart_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
    logic [1:0] addr0 = 2'b00, addr1 = 2'b00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       tbr = 1'b0;
    logic       lock0 = 1'b0, lock1 = 1'b0;

    logic       gnt0_a, gnt1_a, done0_a, done1_a, err_a, iocs_a, iorw_a;
    logic [1:0] ioaddr_a;
    logic [7:0] rdata_a;
    logic       gnt0_b, gnt1_b, done0_b, done1_b, err_b, iocs_b, iorw_b;
    logic [1:0] ioaddr_b;
    logic [7:0] rdata_b;

    logic       tb_en_a = 1'b0, tb_en_b = 1'b0;
    logic [7:0] tb_drv_a = 8'h00, tb_drv_b = 8'hA5;
    wire  [7:0] databus_a, databus_b;
    assign databus_a = tb_en_a ? tb_drv_a : 8'hzz;
    assign databus_b = tb_en_b ? tb_drv_b : 8'hzz;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spart_bus_arbiter u_dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_a), .done0(done0_a),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_a), .done1(done1_a),
`ifdef SPART_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rdata(rdata_a), .err(err_a), .iocs(iocs_a), .iorw(iorw_a), .ioaddr(ioaddr_a),
        .databus(databus_a), .tbr(tbr)
    );

    spart_bus_arbiter #(.TBR_TIMEOUT(16'd8)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_b), .done0(done0_b),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_b), .done1(done1_b),
`ifdef SPART_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rdata(rdata_b), .err(err_b), .iocs(iocs_b), .iorw(iorw_b), .ioaddr(ioaddr_b),
        .databus(databus_b), .tbr(tbr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        rst  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Full read on instance a, starting and ending at a negedge with the arbiter idle.
    task automatic run_read(input bit id, input logic [1:0] a, input logic [7:0] d);
        tb_en_a  = 1'b1;
        tb_drv_a = d;
        if (id) begin req1 = 1'b1; rw1 = 1'b1; addr1 = a; end
        else    begin req0 = 1'b1; rw0 = 1'b1; addr0 = a; end
        @(negedge clk);
        check_eq("rd_gnt", id ? gnt1_a : gnt0_a, 1);
        check_eq("rd_gnt_other", id ? gnt0_a : gnt1_a, 0);
        check_eq("rd_iocs_latch", iocs_a, 0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check_eq("rd_iocs", iocs_a, 1);
        check_eq("rd_iorw", iorw_a, 1);
        check_eq("rd_ioaddr", ioaddr_a, a);
        @(negedge clk);
        check_eq("rd_done", id ? done1_a : done0_a, 1);
        check_eq("rd_rdata", rdata_a, d);
        check_eq("rd_err", err_a, 0);
        check_eq("rd_iocs_done", iocs_a, 0);
        @(negedge clk);
        check_eq("rd_done_clr", id ? done1_a : done0_a, 0);
        check_eq("rd_rdata_hold", rdata_a, d);
    endtask

    initial begin
        int ng;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        // Reset values
        @(negedge clk);
        check_eq("rst_gnt", {gnt0_a, gnt1_a}, 0);
        check_eq("rst_done", {done0_a, done1_a}, 0);
        check_eq("rst_err", err_a, 0);
        check_eq("rst_iocs", iocs_a, 0);
        check_eq("rst_iorw", iorw_a, 1);
        check_eq("rst_ioaddr", ioaddr_a, 0);
        check_eq("rst_rdata", rdata_a, 8'hFF);
        @(negedge clk);
        rst = 1'b1;

        // Basic status read with minimum latency
        run_read(1'b0, 2'b01, 8'h03);

        // Round robin from reset: 0,1,0,1
        do_reset();
        tb_en_a = 1'b1; tb_drv_a = 8'h03;
        rw0 = 1'b1; rw1 = 1'b1; addr0 = 2'b01; addr1 = 2'b01;
        req0 = 1'b1; req1 = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            check_eq("rr_excl", 32'(gnt0_a & gnt1_a), 0);
            if (gnt0_a) begin check_eq("rr_order", 0, 32'(ng % 2)); ng++; req0 = 1'b0; end
            if (gnt1_a) begin check_eq("rr_order", 1, 32'(ng % 2)); ng++; req1 = 1'b0; end
            if (done0_a && ng < 4) req0 = 1'b1;
            if (done1_a && ng < 4) req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        check_eq("rr_count", 32'(ng), 4);
        repeat (3) @(negedge clk);

        // Transmit write gated on tbr for 10 cycles
        tb_en_a = 1'b0; tbr = 1'b0;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 2'b00; wdata1 = 8'h5A;
        @(negedge clk);
        check_eq("tw_gnt1", gnt1_a, 1);
        req1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("tw_wait_iocs", iocs_a, 0);
            check_eq("tw_wait_done", done1_a, 0);
        end
        tbr = 1'b1;
        @(negedge clk);
        check_eq("tw_iocs", iocs_a, 1);
        check_eq("tw_iorw", iorw_a, 0);
        check_eq("tw_ioaddr", ioaddr_a, 0);
        check_eq("tw_data", databus_a, 8'h5A);
        @(negedge clk);
        check_eq("tw_done1", done1_a, 1);
        check_eq("tw_err", err_a, 0);
        check_eq("tw_iocs_off", iocs_a, 0);
        @(negedge clk);

        // Timeout on instance b (TBR_TIMEOUT = 8)
        do_reset();
        tbr = 1'b0; tb_en_b = 1'b1; tb_drv_b = 8'hA5;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 2'b00; wdata0 = 8'h77;
        @(negedge clk);
        check_eq("to_gnt0", gnt0_b, 1);
        req0 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("to_wait_done", done0_b, 0);
            check_eq("to_wait_iocs", iocs_b, 0);
            check_eq("to_bus", databus_b, 8'hA5);
        end
        @(negedge clk);
        check_eq("to_done0", done0_b, 1);
        check_eq("to_err", err_b, 1);
        check_eq("to_iocs", iocs_b, 0);
        check_eq("to_bus_done", databus_b, 8'hA5);
        @(negedge clk);
        check_eq("to_err_clr", err_b, 0);
        check_eq("to_done_clr", done0_b, 0);
        tb_en_b = 1'b0;

        // Reset during WAIT_TBR
        do_reset();
        req1 = 1'b1; rw1 = 1'b0; addr1 = 2'b00; wdata1 = 8'hC3;
        @(negedge clk);
        check_eq("rw_gnt1", gnt1_a, 1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rw_iocs", iocs_a, 0);
        check_eq("rw_iorw", iorw_a, 1);
        @(negedge clk);
        check_eq("rw_done", done1_a, 0);
        check_eq("rw_err", err_a, 0);
        rst = 1'b1;
        run_read(1'b1, 2'b01, 8'h3C);

        // Reset during ISSUE of a read
        tb_en_a = 1'b1; tb_drv_a = 8'h42;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 2'b10;
        @(negedge clk);
        check_eq("ri_gnt0", gnt0_a, 1);
        req0 = 1'b0;
        @(negedge clk);
        check_eq("ri_iocs_pre", iocs_a, 1);
        rst = 1'b0;
        #1;
        check_eq("ri_iocs", iocs_a, 0);
        check_eq("ri_iorw", iorw_a, 1);
        check_eq("ri_ioaddr", ioaddr_a, 0);
        check_eq("ri_rdata", rdata_a, 8'hFF);
        @(negedge clk);
        check_eq("ri_done", done0_a, 0);
        rst = 1'b1;
        run_read(1'b0, 2'b11, 8'h99);

`ifdef SPART_ARB_LOCK_EN
        // Locked div-lo/div-hi pair completes before requester 1 is granted
        do_reset();
        tb_en_a = 1'b0; tbr = 1'b1;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 2'b10; wdata0 = 8'h11; lock0 = 1'b1;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 2'b01; wdata1 = 8'h22;
        ng = 0;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            @(negedge clk);
            if (gnt0_a) begin
                check_eq("lk_order", 0, (ng == 2) ? 1 : 0);
                ng++; req0 = 1'b0;
                if (ng == 2) lock0 = 1'b0;
            end
            if (gnt1_a) begin
                check_eq("lk_order", 1, (ng == 2) ? 1 : 0);
                ng++; req1 = 1'b0;
            end
            if (done0_a && ng == 1) begin
                req0 = 1'b1; addr0 = 2'b11; wdata0 = 8'h33;
            end
        end
        check_eq("lk_count", 32'(ng), 3);
        repeat (3) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
